// File: rtl/kan_sched_pkg.sv
// Shared types and defaults for the KAN multi-core job scheduler.
package kan_sched_pkg;

  localparam int DEF_NUM_CORES      = 8;
  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_LANES          = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_CNT_WIDTH      = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_WAIT,
    ST_DRAIN,
    ST_DONE
  } sched_state_t;

  // A single core still needs a one-bit ID field.
  function automatic int core_id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/kan_rr_arbiter.sv
// Rotate-priority encoder: picks the first request after last_grant, wrapping to 0.
module kan_rr_arbiter
  import kan_sched_pkg::*;
#(
  parameter int N  = DEF_NUM_CORES,
  parameter int IW = core_id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [IW-1:0] grant,
  output logic          any_grant
);

  int idx;

  // NOTE: combinational logic uses blocking '='; every output gets a default
  // before the loop so no path can leave a value unassigned and infer a latch.
  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant) + k) % N;
      if (!any_grant && req[idx]) begin
        any_grant = 1'b1;
        grant     = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/kan_multi_core_scheduler.sv
// Job scheduler for a KAN core array: dispatch, capture with timeout, round-robin drain.
module kan_multi_core_scheduler
  import kan_sched_pkg::*;
#(
  parameter int NUM_CORES      = DEF_NUM_CORES,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int LANES          = DEF_LANES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
  localparam int ID_W          = core_id_width(NUM_CORES),
  localparam int SLICE_W       = LANES * DATA_WIDTH,
  localparam int TIMER_W       = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           job_valid,
  input  logic [NUM_CORES-1:0]           job_mask,
  output logic                           job_ready,
  output logic [NUM_CORES-1:0]           core_start,
  input  logic [NUM_CORES-1:0]           core_done,
  input  logic [NUM_CORES*SLICE_W-1:0]   core_result,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [ID_W-1:0]                res_core_id,
  output logic [SLICE_W-1:0]             res_data,
  output logic                           job_done,
  output logic [NUM_CORES-1:0]           timeout_mask,
  output logic                           busy,
  output logic [NUM_CORES*CNT_WIDTH-1:0] done_count
);

  sched_state_t state, next_state;

  logic [NUM_CORES-1:0] pending;
  logic [NUM_CORES-1:0] captured;
  logic [TIMER_W-1:0]   timer;
  logic [ID_W-1:0]      last_grant;
  logic [CNT_WIDTH-1:0] cnt     [NUM_CORES];
  logic [SLICE_W-1:0]   res_buf [NUM_CORES];

  logic                 accept;
  logic [NUM_CORES-1:0] capture;
  logic [NUM_CORES-1:0] pending_after;
  logic                 timer_expired;
  logic [ID_W-1:0]      grant;
  logic                 any_grant;
  logic                 beat;
  logic [NUM_CORES-1:0] captured_after;

  kan_rr_arbiter #(
    .N  (NUM_CORES),
    .IW (ID_W)
  ) u_arb (
    .req        (captured),
    .last_grant (last_grant),
    .grant      (grant),
    .any_grant  (any_grant)
  );

  // Done pulses only count while waiting and only for cores still owed a result.
  assign accept         = job_valid && (state == ST_IDLE);
  assign capture        = (state == ST_WAIT) ? (core_done & pending) : '0;
  assign pending_after  = pending & ~capture;
  assign timer_expired  = (timer == TIMER_W'(TIMEOUT_CYCLES - 1));
  assign beat           = res_valid && res_ready;
  assign captured_after = beat ? (captured & ~(NUM_CORES'(1) << grant)) : captured;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:     if (job_valid) next_state = (job_mask != '0) ? ST_DISPATCH : ST_DONE;
      ST_DISPATCH: next_state = ST_WAIT;
      ST_WAIT:     if (pending_after == '0 || timer_expired) next_state = ST_DRAIN;
      ST_DRAIN:    if (captured_after == '0) next_state = ST_DONE;
      ST_DONE:     next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    job_ready   = (state == ST_IDLE);
    busy        = (state != ST_IDLE);
    job_done    = (state == ST_DONE);
    res_valid   = (state == ST_DRAIN) && any_grant;
    res_core_id = res_valid ? grant : '0;
    res_data    = res_valid ? res_buf[grant] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= '0;
      captured     <= '0;
      timer        <= '0;
      last_grant   <= ID_W'(NUM_CORES - 1);
      core_start   <= '0;
      timeout_mask <= '0;
    end else begin
      core_start <= accept ? job_mask : '0;
      if (accept) begin
        pending      <= job_mask;
        captured     <= '0;
        timeout_mask <= '0;
      end
      if (state == ST_DISPATCH) timer <= '0;
      if (state == ST_WAIT) begin
        timer    <= timer + TIMER_W'(1);
        captured <= captured | capture;
        pending  <= timer_expired ? '0 : pending_after;
        if (timer_expired) timeout_mask <= pending_after;
      end
      if (state == ST_DRAIN) captured <= captured_after;
      if (beat) last_grant <= grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CORES; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++)
        if (capture[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + CNT_WIDTH'(1);
    end
  end

  // NOTE: the result buffer is plain storage with no reset; its contents are
  // only visible through res_data when the matching captured bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++)
      if (capture[i]) res_buf[i] <= core_result[i*SLICE_W +: SLICE_W];
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_cnt
    assign done_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt[g];
  end

endmodule
